// File: rtl/hqm_event_outstanding_tracker.sv
// Per-channel outstanding-event counter with underflow, overflow and watchdog-timeout sticky errors.
// Latency: one cycle from event to count/flag. No backpressure: every event is accepted and accounted.
module hqm_event_outstanding_tracker #(
  parameter int WIDTH     = 1,
  parameter int CNT_WIDTH = 16,
  parameter int TMO_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           start_event,
  input  logic [WIDTH-1:0]           end_event,
  input  logic [TMO_WIDTH-1:0]       cfg_timeout,
  input  logic                       clr_error,
  output logic [WIDTH*CNT_WIDTH-1:0] outstanding,
  output logic                       idle,
  output logic [WIDTH-1:0]           error_underflow,
  output logic [WIDTH-1:0]           error_overflow,
  output logic [WIDTH-1:0]           error_timeout,
  output logic                       error_v
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [TMO_WIDTH-1:0] TMO_MAX = '1;
  localparam logic [TMO_WIDTH-1:0] TMO_ONE = TMO_WIDTH'(1);

  logic [CNT_WIDTH-1:0] cnt_q [WIDTH];
  logic [CNT_WIDTH-1:0] cnt_d [WIDTH];
  logic [TMO_WIDTH-1:0] tmr_q [WIDTH];
  logic [TMO_WIDTH-1:0] tmr_d [WIDTH];
  logic [WIDTH-1:0]     eu_q, eu_d, eo_q, eo_d, et_q, et_d;
  logic [WIDTH-1:0]     new_u, new_o, new_t;
  logic                 idle_q, idle_d;

  always_comb begin
    idle_d = 1'b1;
    new_u  = '0;
    new_o  = '0;
    new_t  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      tmr_d[i] = tmr_q[i];
      case ({start_event[i], end_event[i]})
        2'b10: begin
          if (cnt_q[i] == CNT_MAX) new_o[i] = 1'b1;
          else                     cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
        2'b01: begin
          if (cnt_q[i] == '0) new_u[i] = 1'b1;
          else                cnt_d[i] = cnt_q[i] - CNT_ONE;
        end
        default: ;
      endcase
      // Timer measures time since the last retirement while work is pending.
      if (end_event[i] || (cnt_d[i] == '0))
        tmr_d[i] = '0;
      else if ((cnt_q[i] != '0) && (tmr_q[i] != TMO_MAX))
        tmr_d[i] = tmr_q[i] + TMO_ONE;
      new_t[i] = (cfg_timeout != '0) && (tmr_q[i] == cfg_timeout);
      if (cnt_d[i] != '0) idle_d = 1'b0;
    end
    // A fresh error in the clearing cycle still sets its bit.
    eu_d = (clr_error ? '0 : eu_q) | new_u;
    eo_d = (clr_error ? '0 : eo_q) | new_o;
    et_d = (clr_error ? '0 : et_q) | new_t;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
        tmr_q[i] <= '0;
      end
      eu_q   <= '0;
      eo_q   <= '0;
      et_q   <= '0;
      idle_q <= 1'b1;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
        tmr_q[i] <= tmr_d[i];
      end
      eu_q   <= eu_d;
      eo_q   <= eo_d;
      et_q   <= et_d;
      idle_q <= idle_d;
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_out
    assign outstanding[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q[g];
  end

  assign idle            = idle_q;
  assign error_underflow = eu_q;
  assign error_overflow  = eo_q;
  assign error_timeout   = et_q;
  assign error_v         = |{eu_q, eo_q, et_q};

endmodule

// File: tb/tb_hqm_event_outstanding_tracker.sv
// Bench for hqm_event_outstanding_tracker: behavioural model feeds a scoreboard of expected outputs.
module tb_hqm_event_outstanding_tracker;
  localparam int W  = 2;
  localparam int CW = 4;
  localparam int TW = 16;

  typedef struct packed {
    logic [W*CW-1:0] out;
    logic            idle;
    logic [W-1:0]    eu;
    logic [W-1:0]    eo;
    logic [W-1:0]    et;
    logic            ev;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [W-1:0]    start_event, end_event;
  logic [TW-1:0]   cfg_timeout;
  logic            clr_error;
  logic [W*CW-1:0] outstanding;
  logic            idle, error_v;
  logic [W-1:0]    error_underflow, error_overflow, error_timeout;

  hqm_event_outstanding_tracker #(.WIDTH(W), .CNT_WIDTH(CW), .TMO_WIDTH(TW)) dut (
    .clk(clk), .rst_n(rst_n), .start_event(start_event), .end_event(end_event),
    .cfg_timeout(cfg_timeout), .clr_error(clr_error), .outstanding(outstanding),
    .idle(idle), .error_underflow(error_underflow), .error_overflow(error_overflow),
    .error_timeout(error_timeout), .error_v(error_v)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  exp_t sb[$];

  logic [CW-1:0] m_cnt [W];
  logic [TW-1:0] m_tmr [W];
  logic [W-1:0]  m_eu, m_eo, m_et;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < W; i++) begin
      m_cnt[i] = '0;
      m_tmr[i] = '0;
    end
    m_eu = '0; m_eo = '0; m_et = '0;
  endtask

  task automatic model_adv(input logic [W-1:0] s, input logic [W-1:0] e, input logic c);
    logic [W-1:0] nu, no, nt;
    logic [CW-1:0] nc;
    nu = '0; no = '0; nt = '0;
    for (int i = 0; i < W; i++) begin
      nc = m_cnt[i];
      if (s[i] && !e[i]) begin
        if (m_cnt[i] == 4'hF) no[i] = 1'b1; else nc = m_cnt[i] + 4'd1;
      end else if (e[i] && !s[i]) begin
        if (m_cnt[i] == 4'h0) nu[i] = 1'b1; else nc = m_cnt[i] - 4'd1;
      end
      nt[i] = (cfg_timeout != 0) && (m_tmr[i] == cfg_timeout);
      if (e[i] || nc == 0)                          m_tmr[i] = '0;
      else if (m_cnt[i] != 0 && m_tmr[i] != 16'hFFFF) m_tmr[i] = m_tmr[i] + 16'd1;
      m_cnt[i] = nc;
    end
    m_eu = (c ? '0 : m_eu) | nu;
    m_eo = (c ? '0 : m_eo) | no;
    m_et = (c ? '0 : m_et) | nt;
  endtask

  function automatic exp_t cur_exp();
    exp_t x;
    x.out  = {m_cnt[1], m_cnt[0]};
    x.idle = (m_cnt[0] == 0) && (m_cnt[1] == 0);
    x.eu   = m_eu;
    x.eo   = m_eo;
    x.et   = m_et;
    x.ev   = |{m_eu, m_eo, m_et};
    return x;
  endfunction

  task automatic compare_all(input exp_t x);
    check("outstanding", outstanding, x.out);
    check("idle", idle, x.idle);
    check("error_underflow", error_underflow, x.eu);
    check("error_overflow", error_overflow, x.eo);
    check("error_timeout", error_timeout, x.et);
    check("error_v", error_v, x.ev);
  endtask

  task automatic step(input logic [W-1:0] s, input logic [W-1:0] e, input logic c);
    exp_t x;
    @(negedge clk);
    start_event = s; end_event = e; clr_error = c;
    model_adv(s, e, c);
    sb.push_back(cur_exp());
    @(posedge clk);
    #1;
    if (sb.size() == 0) check("sb_empty", 1, 0);
    else begin
      x = sb.pop_front();
      compare_all(x);
    end
    start_event = '0; end_event = '0; clr_error = 1'b0;
  endtask

  task automatic idle_steps(input int n);
    for (int k = 0; k < n; k++) step('0, '0, 1'b0);
  endtask

  initial begin
    int seq [6];
    seq = '{1, 2, 3, 2, 1, 0};
    rst_n = 1'b0; start_event = '0; end_event = '0; cfg_timeout = '0; clr_error = 1'b0;
    model_reset();
    #12;
    check("rst_outstanding", outstanding, 0);
    check("rst_idle", idle, 1);
    check("rst_err_v", error_v, 0);
    @(negedge clk); rst_n = 1'b1;

    for (int k = 0; k < 6; k++) begin
      step((k < 3) ? 2'b01 : 2'b00, (k < 3) ? 2'b00 : 2'b01, 1'b0);
      check("seq_cnt", outstanding[CW-1:0], seq[k]);
      check("seq_idle", idle, (seq[k] == 0));
    end
    check("seq_no_err", error_v, 0);

    step(2'b00, 2'b10, 1'b0);
    check("ufl_bits", error_underflow, 2'b10);
    check("ufl_ev", error_v, 1);
    check("ufl_cnt1", outstanding[2*CW-1:CW], 0);
    step(2'b00, 2'b00, 1'b1);
    check("ufl_clr", error_underflow, 0);

    cfg_timeout = 16'd10;
    step(2'b01, 2'b00, 1'b0);
    for (int j = 1; j <= 11; j++) begin
      step(2'b00, 2'b00, 1'b0);
      if (j == 10) check("tmo_early", error_timeout, 2'b00);
      if (j == 11) check("tmo_fire", error_timeout, 2'b01);
    end
    step(2'b00, 2'b01, 1'b0);
    step(2'b00, 2'b00, 1'b1);

    step(2'b01, 2'b00, 1'b0);
    idle_steps(8);
    step(2'b00, 2'b01, 1'b0);
    idle_steps(15);
    check("tmo_none", error_timeout, 2'b00);
    cfg_timeout = '0;

    for (int k = 0; k < 15; k++) step(2'b01, 2'b00, 1'b0);
    check("ovf_full", outstanding[CW-1:0], 15);
    check("ovf_none_yet", error_overflow, 2'b00);
    step(2'b01, 2'b00, 1'b0);
    check("ovf_hold", outstanding[CW-1:0], 15);
    check("ovf_bit", error_overflow, 2'b01);
    step(2'b01, 2'b01, 1'b0);
    check("ovf_both_cnt", outstanding[CW-1:0], 15);
    check("ovf_both_ufl", error_underflow, 2'b00);

    step(2'b00, 2'b10, 1'b1);
    check("clr_wins_ufl", error_underflow, 2'b10);
    check("clr_ovf", error_overflow, 2'b00);

    cfg_timeout = 16'd5;
    for (int k = 0; k < 60; k++)
      step(W'($urandom_range(0, 3)), W'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0));

    step(2'b01, 2'b00, 1'b0);
    step(2'b01, 2'b00, 1'b0);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_outstanding", outstanding, 0);
    check("arst_idle", idle, 1);
    check("arst_eu", error_underflow, 0);
    check("arst_eo", error_overflow, 0);
    check("arst_et", error_timeout, 0);
    check("arst_ev", error_v, 0);
    rst_n = 1'b1;
    step(2'b01, 2'b00, 1'b0);
    check("post_rst_cnt", outstanding[CW-1:0], 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
